// File: rtl/tl_a_arbiter_pkg.sv
// Shared TileLink A-channel types, opcodes and beat-count helpers for the
// A-channel arbiter and its round-robin picker.
package tl_a_arbiter_pkg;

   localparam int DATA_BITS   = 64;
   localparam int SIZE_BITS   = 4;
   localparam int SOURCE_BITS = 4;
   localparam int ADDR_BITS   = 32;
   localparam int BEAT_BYTES  = DATA_BITS / 8;
   localparam int LG_BEAT     = $clog2(BEAT_BYTES);
   localparam int CNT_W       = SIZE_BITS;
   localparam int BEAT_W      = CNT_W + 1;

   typedef enum logic [2:0] {
      PUT_FULL_DATA    = 3'd0,
      PUT_PARTIAL_DATA = 3'd1,
      ARITHMETIC_DATA  = 3'd2,
      LOGICAL_DATA     = 3'd3,
      GET              = 3'd4,
      HINT             = 3'd5,
      ACQUIRE_BLOCK    = 3'd6,
      ACQUIRE_PERM     = 3'd7
   } tl_a_opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [2:0]             param;
      logic [SIZE_BITS-1:0]   size;
      logic [SOURCE_BITS-1:0] source;
      logic [ADDR_BITS-1:0]   address;
      logic [BEAT_BYTES-1:0]  mask;
      logic [DATA_BITS-1:0]   data;
      logic                   corrupt;
   } tl_bundle_a_t;

   function automatic logic tl_has_data_a(input logic [2:0] opcode);
      return opcode < 3'(GET);
   endfunction

   // Only data-carrying messages larger than one beat span multiple beats.
   function automatic logic [BEAT_W-1:0] tl_num_beats(input logic [2:0] opcode,
                                                      input logic [SIZE_BITS-1:0] size);
      logic [BEAT_W-1:0] beats;
      if (tl_has_data_a(opcode) && (size > SIZE_BITS'(LG_BEAT))) begin
         beats = BEAT_W'(1) << (size - SIZE_BITS'(LG_BEAT));
      end else begin
         beats = BEAT_W'(1);
      end
      return beats;
   endfunction

endpackage

// File: rtl/tl_a_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N_REQ. Shared by the A- and D-channel arbiters.
module rr_pick #(
   parameter int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0] idx_o
);

   // Scan from the pointer upward; the first hit wins.
   always_comb begin
      logic             found;
      logic [PTR_W-1:0] cand;
      found = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand  = PTR_W'((int'(ptr_i) + i) % N_REQ);
         idx_o = (!found && req_i[cand]) ? cand : idx_o;
         found = found | req_i[cand];
      end
      gnt_o = found ? (N_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/tl_a_arbiter.sv
// N-to-1 TileLink A-channel arbiter: round-robin between requesters, holding a
// stalled message stable and locking multi-beat bursts to their owner.
module tl_a_arbiter
   import tl_a_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic         [N_REQ-1:0]       a_valid_i,
   output logic         [N_REQ-1:0]       a_ready_o,
   input  tl_bundle_a_t [N_REQ-1:0]       a_bits_i,
   output logic                           a_valid_o,
   input  logic                           a_ready_i,
   output tl_bundle_a_t                   a_bits_o,
   output logic         [N_REQ-1:0]       grant_o,
   output logic                           busy_o
);

   localparam int PTR_W = $clog2(N_REQ);

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;

   logic [N_REQ-1:0]  pick_gnt;
   logic [PTR_W-1:0]  pick_idx;
   logic [PTR_W-1:0]  sel;
   logic              hs;
   logic [BEAT_W-1:0] beats;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i (a_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // Routing: a fresh pick only in IDLE; otherwise the owner keeps the port.
   always_comb begin
      sel       = (state_q == ST_IDLE) ? pick_idx : owner_q;
      a_bits_o  = a_bits_i[sel];
      a_valid_o = a_valid_i[sel];
      grant_o   = (state_q == ST_IDLE) ? pick_gnt : (N_REQ'(1) << owner_q);
      a_ready_o = grant_o & {N_REQ{a_ready_i}};
      hs        = a_valid_o & a_ready_i;
      beats     = tl_num_beats(a_bits_o.opcode, a_bits_o.size);
      busy_o    = (state_q != ST_IDLE);
   end

   // Next-state logic for arbitration state, pointer, owner and beat count.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (beats == BEAT_W'(1)) begin
                  ptr_d = ptr_next(sel);
               end else begin
                  state_d     = ST_LOCK;
                  owner_d     = sel;
                  remaining_d = CNT_W'(beats - BEAT_W'(1));
               end
            end else if (a_valid_o) begin
               state_d = ST_HOLD;
               owner_d = sel;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (hs) begin
               if (beats == BEAT_W'(1)) begin
                  state_d = ST_IDLE;
                  ptr_d   = ptr_next(owner_q);
               end else begin
                  state_d     = ST_LOCK;
                  remaining_d = CNT_W'(beats - BEAT_W'(1));
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_LOCK: begin
            if (hs) begin
               if (remaining_q == CNT_W'(1)) begin
                  state_d     = ST_IDLE;
                  ptr_d       = ptr_next(owner_q);
                  remaining_d = '0;
               end else begin
                  remaining_d = remaining_q - CNT_W'(1);
               end
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any partial burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Scoreboard bench for tl_a_arbiter: directed requester queues feed the DUT,
// a negedge monitor checks every downstream handshake against expected beats.
module tb_tl_a_arbiter;
   import tl_a_arbiter_pkg::*;

   localparam int N = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic         [N-1:0]   a_valid_i;
   logic         [N-1:0]   a_ready_o;
   tl_bundle_a_t [N-1:0]   a_bits_i;
   logic                   a_valid_o;
   logic                   a_ready_i;
   tl_bundle_a_t           a_bits_o;
   logic         [N-1:0]   grant_o;
   logic                   busy_o;

   typedef struct {
      int           idx;
      tl_bundle_a_t bits;
   } exp_t;

   exp_t         exp_q[$];
   tl_bundle_a_t req_q[N][$];
   logic [N-1:0] mute;
   int           checks = 0;
   int           failures = 0;

   tl_a_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid_i (a_valid_i),
      .a_ready_o (a_ready_o),
      .a_bits_i  (a_bits_i),
      .a_valid_o (a_valid_o),
      .a_ready_i (a_ready_i),
      .a_bits_o  (a_bits_o),
      .grant_o   (grant_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic tl_bundle_a_t mk(input logic [2:0] op, input logic [SIZE_BITS-1:0] size,
                                       input int src, input int id);
      tl_bundle_a_t m;
      m         = '0;
      m.opcode  = op;
      m.size    = size;
      m.source  = SOURCE_BITS'(src);
      m.address = ADDR_BITS'(id);
      m.mask    = 8'hFF;
      m.data    = {32'(id), ~32'(id)};
      return m;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every downstream handshake must match the next expected beat.
   always @(negedge clk) begin
      if (rst_n && a_valid_o && a_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_hs: got grant %b with no beat expected", grant_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hs_grant", 128'(grant_o), 128'(oh(e.idx)));
            chk("hs_bits", 128'(a_bits_o), 128'(e.bits));
            chk("hs_ready", 128'(a_ready_o), 128'(oh(e.idx)));
         end
      end
   end

   task automatic push(input int r, input tl_bundle_a_t m);
      req_q[r].push_back(m);
   endtask

   task automatic expect_beat(input int r, input tl_bundle_a_t m);
      exp_t e;
      e.idx  = r;
      e.bits = m;
      exp_q.push_back(e);
   endtask

   task automatic drive();
      for (int r = 0; r < N; r++) begin
         a_valid_i[r] = (req_q[r].size() > 0) && !mute[r];
         a_bits_i[r]  = (req_q[r].size() > 0) ? req_q[r][0] : '0;
      end
   endtask

   // One cycle: sample accepted requesters, cross the edge, retire and redrive.
   task automatic step();
      logic [N-1:0] hs;
      #2;
      hs = a_valid_i & a_ready_o;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
         if (hs[r] && req_q[r].size() > 0) void'(req_q[r].pop_front());
      end
      drive();
   endtask

   task automatic drain(input string name);
      int n;
      int pend;
      n = 0;
      pend = 1;
      while (pend != 0 && n < 200) begin
         step();
         n++;
         pend = exp_q.size();
         for (int r = 0; r < N; r++) pend += req_q[r].size();
      end
      chk({name, "_drained"}, 128'(pend), 128'(0));
      if (pend != 0) begin
         exp_q.delete();
         for (int r = 0; r < N; r++) req_q[r].delete();
         drive();
      end
   endtask

   initial begin
      tl_bundle_a_t m0, m1, m2, m3;
      tl_bundle_a_t bb[8];
      rst_n     = 1'b0;
      a_ready_i = 1'b0;
      mute      = '0;
      a_valid_i = '0;
      a_bits_i  = '0;
      #3;
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_grant", 128'(grant_o), 128'(0));
      chk("rst_valid", 128'(a_valid_o), 128'(0));
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      a_ready_i = 1'b1;

      // 1: alternating single-beat Gets from 0 and 2
      m0 = mk(3'd4, 4'd3, 0, 32'h10); m1 = mk(3'd4, 4'd3, 0, 32'h11);
      m2 = mk(3'd4, 4'd3, 2, 32'h20); m3 = mk(3'd4, 4'd3, 2, 32'h21);
      push(0, m0); push(0, m1); push(2, m2); push(2, m3);
      expect_beat(0, m0); expect_beat(2, m2); expect_beat(0, m1); expect_beat(2, m3);
      drive();
      drain("t1");

      // 2: 4-beat PutFull from 1 locks out the pending Get from 3
      for (int i = 0; i < 4; i++) begin
         bb[i] = mk(3'd0, 4'd5, 1, 32'h30 + i);
         push(1, bb[i]);
         expect_beat(1, bb[i]);
      end
      drive();
      step();
      m3 = mk(3'd4, 4'd3, 3, 32'h40);
      push(3, m3); expect_beat(3, m3);
      drive();
      #1;
      chk("t2_busy_a", 128'(busy_o), 128'(1));
      chk("t2_grant_a", 128'(grant_o), 128'(4'b0010));
      step();
      #1;
      chk("t2_grant_b", 128'(grant_o), 128'(4'b0010));
      step();
      #1;
      chk("t2_grant_c", 128'(grant_o), 128'(4'b0010));
      step();
      #1;
      chk("t2_grant_next", 128'(grant_o), 128'(4'b1000));
      chk("t2_busy_next", 128'(busy_o), 128'(0));
      drain("t2");

      // single Get from 0 moves the pointer to 1
      m0 = mk(3'd4, 4'd3, 0, 32'h50);
      push(0, m0); expect_beat(0, m0);
      drive();
      drain("t3_pre");

      // 3: stalled message from 0 stays put while 1 requests
      a_ready_i = 1'b0;
      m0 = mk(3'd4, 4'd3, 0, 32'h60);
      m1 = mk(3'd4, 4'd3, 1, 32'h61);
      push(0, m0); expect_beat(0, m0);
      drive();
      #1;
      chk("t3_grant_a", 128'(grant_o), 128'(4'b0001));
      step();
      push(1, m1); expect_beat(1, m1);
      drive();
      #1;
      chk("t3_bits_b", 128'(a_bits_o), 128'(m0));
      chk("t3_grant_b", 128'(grant_o), 128'(4'b0001));
      chk("t3_busy_b", 128'(busy_o), 128'(1));
      step();
      #1;
      chk("t3_bits_c", 128'(a_bits_o), 128'(m0));
      chk("t3_grant_c", 128'(grant_o), 128'(4'b0001));
      a_ready_i = 1'b1;
      drain("t3");

      // 4: owner 2 pauses mid-burst; 3 and 0 must wait
      for (int i = 0; i < 4; i++) begin
         bb[i] = mk(3'd0, 4'd5, 2, 32'h70 + i);
         push(2, bb[i]);
         expect_beat(2, bb[i]);
      end
      m3 = mk(3'd4, 4'd3, 3, 32'h80);
      m0 = mk(3'd4, 4'd3, 0, 32'h81);
      push(3, m3); push(0, m0);
      expect_beat(3, m3); expect_beat(0, m0);
      drive();
      step();
      step();
      mute[2] = 1'b1;
      drive();
      #1;
      chk("t4_gap_valid_a", 128'(a_valid_o), 128'(0));
      chk("t4_gap_grant_a", 128'(grant_o), 128'(4'b0100));
      chk("t4_gap_busy_a", 128'(busy_o), 128'(1));
      step();
      #1;
      chk("t4_gap_valid_b", 128'(a_valid_o), 128'(0));
      chk("t4_gap_grant_b", 128'(grant_o), 128'(4'b0100));
      mute[2] = 1'b0;
      drive();
      drain("t4");

      // 5: reset after the first beat of an 8-beat Put from 2
      for (int i = 0; i < 8; i++) begin
         bb[i] = mk(3'd0, 4'd6, 2, 32'h90 + i);
         push(2, bb[i]);
      end
      expect_beat(2, bb[0]);
      drive();
      step();
      m0 = mk(3'd4, 4'd3, 0, 32'hA0);
      m1 = mk(3'd4, 4'd3, 1, 32'hA1);
      push(0, m0); push(1, m1);
      drive();
      #1;
      rst_n     = 1'b0;
      a_ready_i = 1'b0;
      req_q[2].delete();
      drive();
      #1;
      chk("t5_rst_busy", 128'(busy_o), 128'(0));
      chk("t5_rst_valid", 128'(a_valid_o), 128'(1));
      chk("t5_rst_grant", 128'(grant_o), 128'(4'b0001));
      step();
      rst_n     = 1'b1;
      a_ready_i = 1'b1;
      expect_beat(0, m0); expect_beat(1, m1);
      drain("t5");

      // 6: beat counts for PutPartial/Arithmetic/Hint/Acquire vs Gets from 2
      m0 = mk(3'd1, 4'd2, 1, 32'hB0);
      bb[0] = mk(3'd2, 4'd4, 1, 32'hB1);
      bb[1] = mk(3'd2, 4'd4, 1, 32'hB2);
      m1 = mk(3'd5, 4'd6, 1, 32'hB3);
      m2 = mk(3'd6, 4'd6, 1, 32'hB4);
      push(1, m0); push(1, bb[0]); push(1, bb[1]); push(1, m1); push(1, m2);
      for (int i = 0; i < 4; i++) begin
         bb[2 + i] = mk(3'd4, 4'd3, 2, 32'hC0 + i);
         push(2, bb[2 + i]);
      end
      expect_beat(2, bb[2]); expect_beat(1, m0);
      expect_beat(2, bb[3]); expect_beat(1, bb[0]); expect_beat(1, bb[1]);
      expect_beat(2, bb[4]); expect_beat(1, m1);
      expect_beat(2, bb[5]); expect_beat(1, m2);
      drive();
      drain("t6");
      #1;
      chk("t6_end_busy", 128'(busy_o), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
